// File: rtl/ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_monitor
// Description : Syncs an asynchronous ripple count into clk, filters ripple
//               glitches, classifies accepted steps and tallies wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_monitor #(
    parameter int CW            = 3,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     cnt_in,
    input  logic              mode,
    input  logic              clr_wraps,
    output logic [CW-1:0]     cnt_sync,
    output logic              cnt_valid,
    output logic              up_evt,
    output logic              dn_evt,
    output logic              wrap_evt,
    output logic              err_evt,
    output logic [WRAP_W-1:0] wrap_count
);

    localparam int                  c_STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE_CYCLES);
    localparam logic [c_STAB_W-1:0] c_STAB_PRE = c_STAB_W'(STABLE_CYCLES - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_ONE = c_STAB_W'(1);
    localparam logic [CW-1:0]       c_CNT_MAX  = '1;
    localparam logic [CW-1:0]       c_CNT_ONE  = CW'(1);
    localparam logic [WRAP_W-1:0]   c_WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0]   c_WRAP_ONE = WRAP_W'(1);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_TRACK = 1'b1;

    logic [CW-1:0]       r_cnt_s1;
    logic [CW-1:0]       r_cnt_s2;
    logic                r_mode_s1;
    logic                r_mode_s2;
    logic                r_vld_s1;
    logic                r_vld_s2;
    logic [CW-1:0]       r_cand;
    logic                r_cand_vld;
    logic [c_STAB_W-1:0] r_stab;
    logic                r_acc;
    logic [CW-1:0]       r_acc_val;
    logic                r_acc_mode;
    logic [0:0]          r_state;
    logic [CW-1:0]       r_cnt_sync;
    logic                r_cnt_valid;
    logic                r_up_evt;
    logic                r_dn_evt;
    logic                r_wrap_evt;
    logic                r_err_evt;
    logic [WRAP_W-1:0]   r_wrap_count;

    logic                w_load;
    logic                w_reach;
    logic [CW-1:0]       w_delta;

    // The valid pipeline keeps reset-cleared synchronizer zeros from being
    // mistaken for a real count after reset release.
    assign w_load  = r_vld_s2 && (!r_cand_vld || (r_cnt_s2 != r_cand));
    assign w_reach = r_vld_s2 && (w_load ? (STABLE_CYCLES == 1)
                                         : (r_stab == c_STAB_PRE));
    assign w_delta = r_acc_val - r_cnt_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt_s1   <= '0;
            r_cnt_s2   <= '0;
            r_mode_s1  <= 1'b0;
            r_mode_s2  <= 1'b0;
            r_vld_s1   <= 1'b0;
            r_vld_s2   <= 1'b0;
            r_cand     <= '0;
            r_cand_vld <= 1'b0;
            r_stab     <= '0;
            r_acc      <= 1'b0;
            r_acc_val  <= '0;
            r_acc_mode <= 1'b0;
        end else begin
            r_cnt_s1  <= cnt_in;
            r_cnt_s2  <= r_cnt_s1;
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
            r_vld_s1  <= 1'b1;
            r_vld_s2  <= r_vld_s1;
            r_acc     <= w_reach;
            if (w_load) begin
                r_cand     <= r_cnt_s2;
                r_cand_vld <= 1'b1;
                r_stab     <= c_STAB_ONE;
            end else if (r_vld_s2 && (r_stab != c_STAB_MAX)) begin
                r_stab <= r_stab + c_STAB_ONE;
            end
            if (w_reach) begin
                r_acc_val  <= r_cnt_s2;
                r_acc_mode <= r_mode_s2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_INIT;
            r_cnt_sync  <= '0;
            r_cnt_valid <= 1'b0;
            r_up_evt    <= 1'b0;
            r_dn_evt    <= 1'b0;
            r_wrap_evt  <= 1'b0;
            r_err_evt   <= 1'b0;
        end else begin
            r_up_evt   <= 1'b0;
            r_dn_evt   <= 1'b0;
            r_wrap_evt <= 1'b0;
            r_err_evt  <= 1'b0;
            if (r_acc) begin
                case (r_state)
                    c_ST_INIT: begin
                        r_cnt_sync  <= r_acc_val;
                        r_cnt_valid <= 1'b1;
                        r_state     <= c_ST_TRACK;
                    end
                    c_ST_TRACK: begin
                        if (r_acc_val != r_cnt_sync) begin
                            r_cnt_sync <= r_acc_val;
                            if (w_delta == c_CNT_ONE) begin
                                r_up_evt   <= 1'b1;
                                r_err_evt  <= r_acc_mode;
                                r_wrap_evt <= (r_cnt_sync == c_CNT_MAX) && (r_acc_val == '0);
                            end else if (w_delta == c_CNT_MAX) begin
                                r_dn_evt   <= 1'b1;
                                r_err_evt  <= ~r_acc_mode;
                                r_wrap_evt <= (r_cnt_sync == '0) && (r_acc_val == c_CNT_MAX);
                            end else begin
                                r_err_evt <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_ST_INIT;
                endcase
            end
        end
    end

    // Clear takes effect first so a wrap in the same cycle still counts once.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrap_count <= '0;
        end else if (clr_wraps) begin
            r_wrap_count <= r_wrap_evt ? c_WRAP_ONE : '0;
        end else if (r_wrap_evt && (r_wrap_count != c_WRAP_MAX)) begin
            r_wrap_count <= r_wrap_count + c_WRAP_ONE;
        end
    end

    assign cnt_sync   = r_cnt_sync;
    assign cnt_valid  = r_cnt_valid;
    assign up_evt     = r_up_evt;
    assign dn_evt     = r_dn_evt;
    assign wrap_evt   = r_wrap_evt;
    assign err_evt    = r_err_evt;
    assign wrap_count = r_wrap_count;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_monitor
// Description : Scoreboard bench for ripple_count_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_monitor;

    typedef struct packed {
        logic [2:0] cnt;
        logic       up;
        logic       dn;
        logic       wrap;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] cnt_in;
    logic       mode;
    logic       clr_wraps;
    logic [2:0] cnt_sync;
    logic       cnt_valid;
    logic       up_evt;
    logic       dn_evt;
    logic       wrap_evt;
    logic       err_evt;
    logic [7:0] wrap_count;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    ripple_count_monitor #(.CW(3), .STABLE_CYCLES(2), .WRAP_W(8)) dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .mode(mode),
        .clr_wraps(clr_wraps), .cnt_sync(cnt_sync), .cnt_valid(cnt_valid),
        .up_evt(up_evt), .dn_evt(dn_evt), .wrap_evt(wrap_evt),
        .err_evt(err_evt), .wrap_count(wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any event pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        if (reset && (up_evt || dn_evt || wrap_evt || err_evt)) begin
            obs = '{cnt: cnt_sync, up: up_evt, dn: dn_evt, wrap: wrap_evt, err: err_evt};
            checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event: got cnt/up/dn/wrap/err=%b, none expected", obs);
            end else begin
                e = q.pop_front();
                if (obs !== e)
                    $display("FAIL event: got cnt/up/dn/wrap/err=%b, expected %b", obs, e);
                else
                    passed++;
            end
        end
    end

    task automatic drive_step(input logic [2:0] v, input logic m,
                              input logic u, input logic d, input logic w, input logic er);
        @(negedge clk);
        cnt_in = v;
        mode   = m;
        q.push_back('{cnt: v, up: u, dn: d, wrap: w, err: er});
        repeat (6) @(negedge clk);
        checks++;
        if (q.size() !== 0)
            $display("FAIL step_timeout: value %0d, %0d expectations still pending, required 0", v, q.size());
        else
            passed++;
    endtask

    task automatic test_reset;
        reset = 1'b0; cnt_in = 3'd3; mode = 1'b0; clr_wraps = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cnt_sync, cnt_valid, up_evt, dn_evt, wrap_evt, err_evt, wrap_count} !== 16'h0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {cnt_sync, cnt_valid, up_evt, dn_evt, wrap_evt, err_evt, wrap_count});
        else passed++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (cnt_valid !== 1'b0) $display("FAIL valid_early: got %b, required 0", cnt_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (cnt_valid !== 1'b1) $display("FAIL valid_latency: got %b, required 1", cnt_valid);
        else passed++;
        checks++;
        if (cnt_sync !== 3'd3) $display("FAIL init_value: got %0d, required 3", cnt_sync);
        else passed++;
    endtask

    task automatic test_up_wrap;
        drive_step(3'd4, 1'b0, 1, 0, 0, 0);
        drive_step(3'd5, 1'b0, 1, 0, 0, 0);
        drive_step(3'd6, 1'b0, 1, 0, 0, 0);
        drive_step(3'd7, 1'b0, 1, 0, 0, 0);
        drive_step(3'd0, 1'b0, 1, 0, 1, 0);
        drive_step(3'd1, 1'b0, 1, 0, 0, 0);
        drive_step(3'd2, 1'b0, 1, 0, 0, 0);
        drive_step(3'd3, 1'b0, 1, 0, 0, 0);
        checks++;
        if (wrap_count !== 8'd1) $display("FAIL wrap_count_up: got %0d, required 1", wrap_count);
        else passed++;
    endtask

    task automatic test_down_wrap;
        drive_step(3'd2, 1'b1, 0, 1, 0, 0);
        drive_step(3'd1, 1'b1, 0, 1, 0, 0);
        drive_step(3'd0, 1'b1, 0, 1, 0, 0);
        drive_step(3'd7, 1'b1, 0, 1, 1, 0);
        checks++;
        if (wrap_count !== 8'd2) $display("FAIL wrap_count_dn: got %0d, required 2", wrap_count);
        else passed++;
        drive_step(3'd6, 1'b1, 0, 1, 0, 0);
        drive_step(3'd5, 1'b1, 0, 1, 0, 0);
        drive_step(3'd4, 1'b1, 0, 1, 0, 0);
        drive_step(3'd3, 1'b1, 0, 1, 0, 0);
    endtask

    task automatic test_glitch;
        @(negedge clk);
        mode   = 1'b0;
        cnt_in = 3'd2;
        @(negedge clk);
        cnt_in = 3'd4;
        q.push_back('{cnt: 3'd4, up: 1'b1, dn: 1'b0, wrap: 1'b0, err: 1'b0});
        repeat (6) @(negedge clk);
        checks++;
        if (q.size() !== 0) $display("FAIL glitch_step: %0d pending, required 0", q.size());
        else passed++;
        checks++;
        if (cnt_sync !== 3'd4) $display("FAIL glitch_value: got %0d, required 4", cnt_sync);
        else passed++;
        drive_step(3'd6, 1'b0, 0, 0, 0, 1);
    endtask

    task automatic test_against_mode_and_clear;
        bit seen;
        drive_step(3'd5, 1'b1, 0, 1, 0, 0);
        drive_step(3'd6, 1'b1, 1, 0, 0, 1);
        drive_step(3'd7, 1'b0, 1, 0, 0, 0);
        @(negedge clk);
        cnt_in = 3'd0;
        q.push_back('{cnt: 3'd0, up: 1'b1, dn: 1'b0, wrap: 1'b1, err: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = wrap_evt;
        end
        checks++;
        if (!seen) $display("FAIL wrap_timeout: wrap_evt got 0, required 1");
        else passed++;
        clr_wraps = 1'b1;
        @(negedge clk);
        clr_wraps = 1'b0;
        checks++;
        if (wrap_count !== 8'd1) $display("FAIL clr_with_wrap: got %0d, required 1", wrap_count);
        else passed++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        reset  = 1'b0;
        cnt_in = 3'd5;
        @(negedge clk);
        checks++;
        if ({cnt_sync, cnt_valid, up_evt, dn_evt, wrap_evt, err_evt, wrap_count} !== 16'h0)
            $display("FAIL mid_reset: got %h, required 0",
                     {cnt_sync, cnt_valid, up_evt, dn_evt, wrap_evt, err_evt, wrap_count});
        else passed++;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (cnt_valid !== 1'b0) $display("FAIL reinit_early: got %b, required 0", cnt_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if ({cnt_valid, cnt_sync} !== {1'b1, 3'd5})
            $display("FAIL reinit_value: got valid/cnt=%b/%0d, required 1/5", cnt_valid, cnt_sync);
        else passed++;
        drive_step(3'd6, 1'b0, 1, 0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_glitch;
        test_against_mode_and_clear;
        test_reset_mid;
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() !== 0) $display("FAIL scoreboard_drain: %0d pending, required 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
